// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample memory for the FFT: one bank fills while the other is read,
// with optional bit-reversed read addressing and frame-level swap control.
module fft_pingpong_ram #(
   parameter int DW       = 32,
   parameter int DEPTH    = 1024,
   parameter int RD_LAT   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_bitrev,
   input  logic          swap,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          wr_bank,
   output logic [AW:0]   wr_cnt,
   output logic          frame_full,
   output logic          swap_err
);

   typedef enum logic {FILLING, READY} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t          r_state;
   logic            r_wrBank;
   logic [AW:0]     r_wrCnt;
   logic            r_swapErr;
   logic [DW-1:0]   r_mem [0:2*DEPTH-1];
   logic            r_rdValid1;
   logic [DW-1:0]   r_rdData1;
   logic [AW-1:0]   w_bitrev;
   logic [AW-1:0]   w_rdPhys;

   always_comb begin
      w_bitrev = '0;
      for (int i = 0; i < AW; i++) begin
         w_bitrev[i] = rd_addr[AW-1-i];
      end
   end

   assign w_rdPhys = rd_bitrev ? w_bitrev : rd_addr;

   // A swap is judged against the registered fill state, so a write on the
   // accepting edge still lands in the old bank but is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FILLING;
         r_wrBank  <= 1'b0;
         r_wrCnt   <= '0;
         r_swapErr <= 1'b0;
      end else begin
         r_swapErr <= 1'b0;
         case (r_state)
            FILLING: begin
               if (swap) begin
                  r_swapErr <= 1'b1;
               end
               if (wr_en) begin
                  r_wrCnt <= r_wrCnt + 1'b1;
                  if (r_wrCnt == FULL_CNT - 1'b1) begin
                     r_state <= READY;
                  end
               end
            end
            READY: begin
               if (swap) begin
                  r_wrBank <= ~r_wrBank;
                  r_wrCnt  <= '0;
                  r_state  <= FILLING;
               end
            end
            default: r_state <= FILLING;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[{r_wrBank, wr_addr}] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdValid1 <= 1'b0;
         r_rdData1  <= '0;
      end else begin
         r_rdValid1 <= rd_en;
         if (rd_en) begin
            r_rdData1 <= r_mem[{~r_wrBank, w_rdPhys}];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          r_rdValid2;
         logic [DW-1:0] r_rdData2;

         // Extra output register; data holds whenever no result arrives.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rdValid2 <= 1'b0;
               r_rdData2  <= '0;
            end else begin
               r_rdValid2 <= r_rdValid1;
               if (r_rdValid1) begin
                  r_rdData2 <= r_rdData1;
               end
            end
         end

         assign rd_valid = r_rdValid2;
         assign rd_data  = r_rdData2;
      end else begin : g_lat1
         assign rd_valid = r_rdValid1;
         assign rd_data  = r_rdData1;
      end
   endgenerate

   assign wr_bank    = r_wrBank;
   assign wr_cnt     = r_wrCnt;
   assign frame_full = (r_state == READY);
   assign swap_err   = r_swapErr;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Drives two copies of the ping-pong RAM (read latency 1 and 2) with the same
// stimulus and compares both against a frame-level reference model.
module tb_fft_pingpong_ram;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;
   logic          rdEn;
   logic [AW-1:0] rdAddr;
   logic          rdBitrev;
   logic          swap;

   logic [DW-1:0] rdData1, rdData2;
   logic          rdValid1, rdValid2;
   logic          wrBank1, wrBank2;
   logic [AW:0]   wrCnt1, wrCnt2;
   logic          frameFull1, frameFull2;
   logic          swapErr1, swapErr2;

   int assertCount = 0;
   int failCount   = 0;

   logic [DW-1:0] mMem [2][DEPTH];
   int            mBank;
   int            mCnt;
   logic          mSwapErr;
   logic          rqValid;
   logic [DW-1:0] rqData;
   logic          exp1Valid, exp2Valid;
   logic [DW-1:0] hold1, hold2;

   fft_pingpong_ram #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(1)) dutLat1 (
      .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_bitrev(rdBitrev), .swap(swap),
      .rd_data(rdData1), .rd_valid(rdValid1), .wr_bank(wrBank1), .wr_cnt(wrCnt1),
      .frame_full(frameFull1), .swap_err(swapErr1)
   );

   fft_pingpong_ram #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(2)) dutLat2 (
      .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
      .rd_en(rdEn), .rd_addr(rdAddr), .rd_bitrev(rdBitrev), .swap(swap),
      .rd_data(rdData2), .rd_valid(rdValid2), .wr_bank(wrBank2), .wr_cnt(wrCnt2),
      .frame_full(frameFull2), .swap_err(swapErr2)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] bitRev(input logic [AW-1:0] a);
      int v = 0;
      for (int i = 0; i < AW; i++) begin
         v = v * 2 + int'((a >> i) & 1);
      end
      return AW'(v);
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: results appear RD_LAT edges after the request, swaps
   // are accepted only on a full frame, and the fill count saturates.
   task automatic modelEdge();
      logic [AW-1:0] pa;
      logic          full;
      exp2Valid = rqValid;
      if (rqValid) hold2 = rqData;
      rqValid = rdEn;
      if (rdEn) begin
         pa     = rdBitrev ? bitRev(rdAddr) : rdAddr;
         rqData = mMem[1 - mBank][pa];
      end
      exp1Valid = rqValid;
      if (rqValid) hold1 = rqData;
      if (wrEn) mMem[mBank][wrAddr] = wrData;
      full     = (mCnt == DEPTH);
      mSwapErr = swap && !full;
      if (swap && full) begin
         mBank = 1 - mBank;
         mCnt  = 0;
      end else if (wrEn && mCnt < DEPTH) begin
         mCnt++;
      end
   endtask

   task automatic modelReset();
      mBank     = 0;
      mCnt      = 0;
      mSwapErr  = 1'b0;
      rqValid   = 1'b0;
      exp1Valid = 1'b0;
      exp2Valid = 1'b0;
      hold1     = '0;
      hold2     = '0;
   endtask

   task automatic checkOutput();
      checkVal("lat1 rd_valid",   64'(rdValid1),   64'(exp1Valid));
      checkVal("lat1 rd_data",    64'(rdData1),    64'(hold1));
      checkVal("lat1 wr_bank",    64'(wrBank1),    64'(mBank));
      checkVal("lat1 wr_cnt",     64'(wrCnt1),     64'(mCnt));
      checkVal("lat1 frame_full", 64'(frameFull1), 64'(mCnt == DEPTH));
      checkVal("lat1 swap_err",   64'(swapErr1),   64'(mSwapErr));
      checkVal("lat2 rd_valid",   64'(rdValid2),   64'(exp2Valid));
      checkVal("lat2 rd_data",    64'(rdData2),    64'(hold2));
      checkVal("lat2 wr_bank",    64'(wrBank2),    64'(mBank));
      checkVal("lat2 wr_cnt",     64'(wrCnt2),     64'(mCnt));
      checkVal("lat2 frame_full", 64'(frameFull2), 64'(mCnt == DEPTH));
      checkVal("lat2 swap_err",   64'(swapErr2),   64'(mSwapErr));
   endtask

   task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic re, input logic [AW-1:0] ra, input logic br,
                                input logic sw);
      wrEn     = we;
      wrAddr   = wa;
      wrData   = wd;
      rdEn     = re;
      rdAddr   = ra;
      rdBitrev = br;
      swap     = sw;
      @(posedge clk);
      #1;
      modelEdge();
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      wrEn = 1'b0; wrAddr = '0; wrData = '0;
      rdEn = 1'b0; rdAddr = '0; rdBitrev = 1'b0; swap = 1'b0;
      modelReset();
      #12;
      checkOutput();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      // Fill bank 0 with 0..7, swap, read back linearly and bit-reversed.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, AW'(i), DW'(i), 1'b0, '0, 1'b0, 1'b0);
      checkVal("full before swap", 64'(frameFull1), 64'd1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      checkVal("bank after swap", 64'(wrBank1), 64'd1);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, 1'b0);
      checkVal("bitrev last word", 64'(rdData1), 64'd7);
      idle();

      // Premature swap after five writes, then complete the frame.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      checkVal("early swap_err", 64'(swapErr1), 64'd1);
      idle();
      checkVal("early cnt kept", 64'(wrCnt1), 64'd5);
      for (int i = 5; i < DEPTH; i++) applyStimulus(1'b1, AW'(i), DW'(32'h100 + i), 1'b0, '0, 1'b0, 1'b0);

      // Write, read and accepted swap on the same edge.
      applyStimulus(1'b1, 3'd3, 32'hAA, 1'b1, 3'd3, 1'b0, 1'b1);
      checkVal("simul old read", 64'(rdData1), 64'd3);
      checkVal("simul cnt clear", 64'(wrCnt1), 64'd0);
      applyStimulus(1'b0, '0, '0, 1'b1, 3'd3, 1'b0, 1'b0);
      checkVal("simul AA visible", 64'(rdData1), 64'hAA);
      idle();

      // Ten writes into an eight-word bank saturate the count.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, AW'(i % DEPTH), DW'(32'h200 + i), 1'b0, '0, 1'b0, 1'b0);
      checkVal("saturated cnt", 64'(wrCnt2), 64'd8);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle();
      applyStimulus(1'b0, '0, '0, 1'b1, 3'd1, 1'b0, 1'b0);
      checkVal("overwrite addr1", 64'(rdData1), 64'h209);

      // Random traffic; every word of both banks has been written by now.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom_range(1)), AW'($urandom), DW'($urandom),
                       1'($urandom_range(1)), AW'($urandom), 1'($urandom_range(1)),
                       1'($urandom_range(5) == 0));
      end

      // Asynchronous reset while a latency-2 read is in flight.
      applyStimulus(1'b0, '0, '0, 1'b1, 3'd2, 1'b0, 1'b0);
      rdEn = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput();
      @(posedge clk);
      #1;
      checkOutput();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
